// File: rtl/util_stream_gen_if.sv
// AXI4-Stream master bundle for util_stream_gen.
// master: the packet generator side; slave: the downstream sink side.
interface util_stream_gen_if #(
    parameter int TBYTE_NUM  = 4,
    parameter int DEST_WIDTH = 5,
    parameter int TID_WIDTH  = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TBYTE_NUM*8-1:0] tdata;
    logic [TBYTE_NUM-1:0]   tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0]  tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest,
        output tready
    );
endinterface

// File: rtl/util_stream_gen.sv
// util_stream_gen: AXI4-Stream packet generator.
// Byte-granular packet length with partial last-beat tkeep, increment/fixed/LFSR
// data patterns, tdest rotation, inter-packet gap and graceful stop.
// Optional statistics counters are built when UTIL_STREAM_GEN_STAT_EN is defined.
module util_stream_gen #(
    parameter int TBYTE_NUM  = 4,
    parameter int DEST_WIDTH = 5,
    parameter int TID_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DEST_WIDTH-1:0]  cfg_dest_base,
    input  logic [DEST_WIDTH-1:0]  cfg_dest_num,
    input  logic [31:0]            cfg_gap,
    input  logic [31:0]            cfg_pkt_num,
    input  logic [31:0]            cfg_len_bytes,
    input  logic [TBYTE_NUM*8-1:0] cfg_start_from,
    input  logic [TBYTE_NUM*8-1:0] cfg_inc,
    input  logic [1:0]             cfg_mode,
    input  logic                   stream_start,
    input  logic                   stream_stop,
    output logic                   stream_busy,
    output logic                   stream_done,
`ifdef UTIL_STREAM_GEN_STAT_EN
    output logic [31:0]            stat_pkt_cnt,
    output logic [31:0]            stat_beat_cnt,
    output logic [31:0]            stat_stall_cnt,
`endif
    util_stream_gen_if.master      m_axis
);
    localparam int DW = TBYTE_NUM * 8;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t                state_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;

    // Configuration latched at the start edge
    logic [DEST_WIDTH-1:0] dest_base_q;
    logic [DEST_WIDTH-1:0] dest_num_q;
    logic [31:0]           gap_q;
    logic [31:0]           pkt_num_q;
    logic [31:0]           beats_q;
    logic [TBYTE_NUM-1:0]  last_keep_q;
    logic [DW-1:0]         start_from_q;
    logic [31:0]           seed_q;
    logic [DW-1:0]         inc_q;
    logic [1:0]            mode_q;

    // Run progress
    logic [31:0]           beat_idx_q;
    logic [31:0]           pkt_cnt_q;
    logic [31:0]           gap_cnt_q;
    logic [DEST_WIDTH-1:0] dest_idx_q;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic [DW-1:0]         data_q;
    logic [31:0]           lfsr_q;

    logic                  start_edge;
    logic                  run_go;
    logic                  hs;
    logic                  is_last;
    logic [31:0]           pkt_next;
    logic                  run_end;
    logic                  dest_wrap;
    logic [31:0]           len_eff;
    logic [31:0]           rem;
    logic [31:0]           beats_calc;
    logic [TBYTE_NUM-1:0]  keep_calc;
    logic [31:0]           seed_raw;
    logic [31:0]           seed_calc;
    logic [31:0]           lfsr_next;
    logic [DW-1:0]         lfsr_fill;

    // Edge detect, packet geometry from the live config, and per-beat decisions
    always_comb begin
        start_edge = stream_start & ~start_q;
        run_go     = (state_q == IDLE) & start_edge;
        hs         = valid_q & m_axis.tready;
        is_last    = (beat_idx_q == beats_q - 32'd1);
        pkt_next   = pkt_cnt_q + 32'd1;
        run_end    = ((pkt_num_q != '1) && (pkt_next == pkt_num_q)) || stream_stop;
        dest_wrap  = (DEST_WIDTH'(dest_idx_q + 1'b1) == dest_num_q);

        len_eff    = (cfg_len_bytes == '0) ? 32'd1 : cfg_len_bytes;
        rem        = len_eff % 32'(TBYTE_NUM);
        // Divide then round up, so lengths near 2^32 cannot overflow
        beats_calc = len_eff / 32'(TBYTE_NUM) + ((rem != '0) ? 32'd1 : 32'd0);
        keep_calc  = '0;
        for (int unsigned i = 0; i < TBYTE_NUM; i++) begin
            keep_calc[i] = (rem == '0) || (i < rem);
        end

        seed_raw   = 32'(cfg_start_from);
        seed_calc  = (seed_raw == '0) ? 32'd1 : seed_raw;

        lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        lfsr_fill  = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            lfsr_fill[i] = lfsr_q[i % 32];
        end
    end

    // Main FSM: IDLE/SEND/GAP/FIN with registered busy, done and tvalid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            dest_base_q  <= '0;
            dest_num_q   <= '0;
            gap_q        <= '0;
            pkt_num_q    <= '0;
            beats_q      <= '0;
            last_keep_q  <= '0;
            start_from_q <= '0;
            seed_q       <= '0;
            inc_q        <= '0;
            mode_q       <= '0;
            beat_idx_q   <= '0;
            pkt_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dest_idx_q   <= '0;
            tdest_q      <= '0;
            data_q       <= '0;
            lfsr_q       <= '0;
        end else begin
            start_q <= stream_start;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        dest_base_q  <= cfg_dest_base;
                        dest_num_q   <= (cfg_dest_num == '0) ? DEST_WIDTH'(1) : cfg_dest_num;
                        gap_q        <= cfg_gap;
                        pkt_num_q    <= cfg_pkt_num;
                        beats_q      <= beats_calc;
                        last_keep_q  <= keep_calc;
                        start_from_q <= cfg_start_from;
                        seed_q       <= seed_calc;
                        inc_q        <= cfg_inc;
                        mode_q       <= cfg_mode;
                        beat_idx_q   <= '0;
                        pkt_cnt_q    <= '0;
                        dest_idx_q   <= '0;
                        tdest_q      <= cfg_dest_base;
                        data_q       <= cfg_start_from;
                        lfsr_q       <= seed_calc;
                        if (cfg_pkt_num == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SEND;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!is_last) begin
                            beat_idx_q <= beat_idx_q + 32'd1;
                            data_q     <= (mode_q == 2'd0) ? data_q + inc_q : data_q;
                            lfsr_q     <= lfsr_next;
                        end else begin
                            beat_idx_q <= '0;
                            pkt_cnt_q  <= pkt_next;
                            data_q     <= start_from_q;
                            lfsr_q     <= seed_q;
                            dest_idx_q <= dest_wrap ? '0 : DEST_WIDTH'(dest_idx_q + 1'b1);
                            tdest_q    <= dest_wrap ? dest_base_q
                                                    : DEST_WIDTH'(dest_base_q + dest_idx_q + 1'b1);
                            if (run_end) begin
                                state_q <= FIN;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (gap_q != '0) begin
                                state_q   <= GAP;
                                valid_q   <= 1'b0;
                                gap_cnt_q <= gap_q;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stream_stop) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q <= 32'd1) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 32'd1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef UTIL_STREAM_GEN_STAT_EN
    // Saturating run statistics, cleared when a run is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_pkt_cnt   <= '0;
            stat_beat_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else if (run_go) begin
            stat_pkt_cnt   <= '0;
            stat_beat_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (hs && stat_beat_cnt != '1) begin
                stat_beat_cnt <= stat_beat_cnt + 32'd1;
            end
            if (hs && is_last && stat_pkt_cnt != '1) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
            if (valid_q && !m_axis.tready && stat_stall_cnt != '1) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

    assign stream_busy   = busy_q;
    assign stream_done   = done_q;
    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = (mode_q == 2'd2) ? lfsr_fill : data_q;
    assign m_axis.tkeep  = valid_q ? (is_last ? last_keep_q : '1) : '0;
    assign m_axis.tlast  = valid_q & is_last;
    assign m_axis.tid    = TID_WIDTH'(pkt_cnt_q);
    assign m_axis.tdest  = tdest_q;

endmodule

// File: tb/tb_util_stream_gen.sv
// Directed testbench for util_stream_gen (TBYTE_NUM=4, DEST_WIDTH=5, TID_WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_util_stream_gen;
    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  cfg_dest_base, cfg_dest_num;
    logic [31:0] cfg_gap, cfg_pkt_num, cfg_len_bytes;
    logic [31:0] cfg_start_from, cfg_inc;
    logic [1:0]  cfg_mode;
    logic        stream_start, stream_stop;
    logic        stream_busy, stream_done;
`ifdef UTIL_STREAM_GEN_STAT_EN
    logic [31:0] stat_pkt_cnt, stat_beat_cnt, stat_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  tid;
        logic [4:0]  dest;
        int          cyc;
        logic        busy;
    } beat_t;

    beat_t beats[$];
    int    done_cnt  = 0;
    logic  done_busy = 1'b0;
    int    valid_cnt = 0;

    util_stream_gen_if #(.TBYTE_NUM(4), .DEST_WIDTH(5), .TID_WIDTH(8)) m_axis_if ();

    util_stream_gen #(.TBYTE_NUM(4), .DEST_WIDTH(5), .TID_WIDTH(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_dest_base  (cfg_dest_base),
        .cfg_dest_num   (cfg_dest_num),
        .cfg_gap        (cfg_gap),
        .cfg_pkt_num    (cfg_pkt_num),
        .cfg_len_bytes  (cfg_len_bytes),
        .cfg_start_from (cfg_start_from),
        .cfg_inc        (cfg_inc),
        .cfg_mode       (cfg_mode),
        .stream_start   (stream_start),
        .stream_stop    (stream_stop),
        .stream_busy    (stream_busy),
        .stream_done    (stream_done),
`ifdef UTIL_STREAM_GEN_STAT_EN
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_beat_cnt  (stat_beat_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .m_axis         (m_axis_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Passive monitor: records handshakes, done pulses and valid cycles
    always @(negedge clk) begin
        if (m_axis_if.tvalid && m_axis_if.tready) begin
            beat_t b;
            b.data = m_axis_if.tdata;
            b.keep = m_axis_if.tkeep;
            b.last = m_axis_if.tlast;
            b.tid  = m_axis_if.tid;
            b.dest = m_axis_if.tdest;
            b.cyc  = cyc;
            b.busy = stream_busy;
            beats.push_back(b);
        end
        if (stream_done) begin
            done_cnt++;
            done_busy = stream_busy;
        end
        if (m_axis_if.tvalid) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic pulse_start();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic set_cfg(input logic [31:0] len, input logic [1:0] mode,
                           input logic [31:0] start_from, input logic [31:0] inc,
                           input logic [31:0] gap, input logic [31:0] pkt_num,
                           input logic [4:0] dbase, input logic [4:0] dnum);
        cfg_len_bytes  = len;
        cfg_mode       = mode;
        cfg_start_from = start_from;
        cfg_inc        = inc;
        cfg_gap        = gap;
        cfg_pkt_num    = pkt_num;
        cfg_dest_base  = dbase;
        cfg_dest_num   = dnum;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        stream_start = 1'b0;
        stream_stop  = 1'b0;
        m_axis_if.tready = 1'b1;
        set_cfg(32'd4, 2'd0, 32'd0, 32'd1, 32'd0, 32'd1, 5'd0, 5'd1);
        #2;
        if (m_axis_if.tvalid !== 1'b0) begin $display("FAIL reset_tvalid got %b exp 0", m_axis_if.tvalid); errors++; end
        checks++;
        if (stream_busy !== 1'b0 || stream_done !== 1'b0) begin $display("FAIL reset_busy_done got %b%b exp 00", stream_busy, stream_done); errors++; end
        checks++;
        if ({m_axis_if.tdata, m_axis_if.tkeep, m_axis_if.tlast, m_axis_if.tid, m_axis_if.tdest} !== '0) begin
            $display("FAIL reset_payload got %h/%h/%b/%h/%h exp all 0", m_axis_if.tdata, m_axis_if.tkeep, m_axis_if.tlast, m_axis_if.tid, m_axis_if.tdest);
            errors++;
        end
        checks++;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        @(negedge clk);
        if (m_axis_if.tvalid !== 1'b0 || stream_busy !== 1'b0) begin $display("FAIL idle_after_reset got v%b b%b exp 0 0", m_axis_if.tvalid, stream_busy); errors++; end
        checks++;
        tick();
    endtask

    task automatic test_incr_b2b();
        logic [31:0] exp_d[6]   = '{0, 1, 0, 1, 0, 1};
        logic        exp_l[6]   = '{0, 1, 0, 1, 0, 1};
        logic [7:0]  exp_tid[6] = '{0, 0, 1, 1, 2, 2};
        bit ok;
        clear_mon();
        set_cfg(32'd8, 2'd0, 32'd0, 32'd1, 32'd0, 32'd3, 5'd0, 5'd1);
        pulse_start();
        wait_done(100, ok);
        if (!ok) begin $display("FAIL incr_done_timeout got none exp done"); errors++; end
        checks++;
        repeat (3) tick();
        if (beats.size() != 6) begin $display("FAIL incr_beat_count got %0d exp 6", beats.size()); errors++; end
        checks++;
        if (beats.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                if (beats[i].data !== exp_d[i] || beats[i].last !== exp_l[i] || beats[i].tid !== exp_tid[i] ||
                    beats[i].keep !== 4'hF || beats[i].busy !== 1'b1) begin
                    $display("FAIL incr_beat%0d got d=%h l=%b id=%h k=%h b=%b exp d=%h l=%b id=%h k=f b=1",
                             i, beats[i].data, beats[i].last, beats[i].tid, beats[i].keep, beats[i].busy,
                             exp_d[i], exp_l[i], exp_tid[i]);
                    errors++;
                end
                checks++;
            end
            if (beats[5].cyc - beats[0].cyc != 5) begin $display("FAIL incr_back_to_back got span %0d exp 5", beats[5].cyc - beats[0].cyc); errors++; end
            checks++;
        end
        if (done_cnt != 1 || done_busy !== 1'b0) begin $display("FAIL incr_done_pulse got cnt=%0d busy=%b exp 1 0", done_cnt, done_busy); errors++; end
        checks++;
    endtask

    task automatic test_fixed_partial();
        logic [3:0] exp_k[3] = '{4'hF, 4'hF, 4'h3};
        logic       exp_l[3] = '{0, 0, 1};
        bit ok;
        clear_mon();
        set_cfg(32'd10, 2'd1, 32'hA5A5A5A5, 32'd7, 32'd0, 32'd1, 5'd7, 5'd0);
        pulse_start();
        wait_done(100, ok);
        if (!ok) begin $display("FAIL fixed_done_timeout got none exp done"); errors++; end
        checks++;
        if (beats.size() != 3) begin $display("FAIL fixed_beat_count got %0d exp 3", beats.size()); errors++; end
        checks++;
        if (beats.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                if (beats[i].data !== 32'hA5A5A5A5 || beats[i].keep !== exp_k[i] ||
                    beats[i].last !== exp_l[i] || beats[i].dest !== 5'd7) begin
                    $display("FAIL fixed_beat%0d got d=%h k=%h l=%b dst=%h exp d=a5a5a5a5 k=%h l=%b dst=07",
                             i, beats[i].data, beats[i].keep, beats[i].last, beats[i].dest, exp_k[i], exp_l[i]);
                    errors++;
                end
                checks++;
            end
        end
        tick();
    endtask

    task automatic test_gap_dest();
        logic [4:0] exp_dst[4] = '{2, 3, 4, 2};
        bit ok;
        clear_mon();
        set_cfg(32'd8, 2'd0, 32'd100, 32'd3, 32'd5, 32'd4, 5'd2, 5'd3);
        pulse_start();
        wait_done(200, ok);
        if (!ok) begin $display("FAIL gap_done_timeout got none exp done"); errors++; end
        checks++;
        if (beats.size() != 8) begin $display("FAIL gap_beat_count got %0d exp 8", beats.size()); errors++; end
        checks++;
        if (beats.size() == 8) begin
            for (int p = 0; p < 4; p++) begin
                if (beats[2*p].data !== 32'd100 || beats[2*p+1].data !== 32'd103 ||
                    beats[2*p].last !== 1'b0 || beats[2*p+1].last !== 1'b1 ||
                    beats[2*p].dest !== exp_dst[p] || beats[2*p+1].dest !== exp_dst[p] ||
                    beats[2*p].tid !== 8'(p)) begin
                    $display("FAIL gap_pkt%0d got d=%h,%h l=%b%b dst=%h id=%h exp d=64,67 l=01 dst=%h id=%h",
                             p, beats[2*p].data, beats[2*p+1].data, beats[2*p].last, beats[2*p+1].last,
                             beats[2*p].dest, beats[2*p].tid, exp_dst[p], 8'(p));
                    errors++;
                end
                checks++;
                if (p > 0) begin
                    if (beats[2*p].cyc - beats[2*p-1].cyc - 1 != 5) begin
                        $display("FAIL gap_idle%0d got %0d exp 5", p, beats[2*p].cyc - beats[2*p-1].cyc - 1);
                        errors++;
                    end
                    checks++;
                end
            end
        end
        tick();
    endtask

    task automatic test_stall();
        logic        pat[6]   = '{1, 0, 0, 1, 0, 1};
        logic [31:0] exp_d[6] = '{10, 15, 15, 15, 20, 20};
        logic        exp_l[6] = '{0, 0, 0, 0, 1, 1};
        bit ok;
        clear_mon();
        set_cfg(32'd12, 2'd0, 32'd10, 32'd5, 32'd0, 32'd1, 5'd0, 5'd1);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            m_axis_if.tready = pat[i];
            @(negedge clk);
            if (m_axis_if.tvalid !== 1'b1 || m_axis_if.tdata !== exp_d[i] || m_axis_if.tlast !== exp_l[i] ||
                m_axis_if.tkeep !== 4'hF || m_axis_if.tid !== 8'd0) begin
                $display("FAIL stall_cyc%0d got v=%b d=%h l=%b k=%h id=%h exp v=1 d=%h l=%b k=f id=00",
                         i, m_axis_if.tvalid, m_axis_if.tdata, m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tid,
                         exp_d[i], exp_l[i]);
                errors++;
            end
            checks++;
            tick();
        end
        m_axis_if.tready = 1'b1;
        wait_done(50, ok);
        if (!ok) begin $display("FAIL stall_done_timeout got none exp done"); errors++; end
        checks++;
        if (beats.size() != 3) begin $display("FAIL stall_beat_count got %0d exp 3", beats.size()); errors++; end
        checks++;
`ifdef UTIL_STREAM_GEN_STAT_EN
        if (stat_stall_cnt !== 32'd3 || stat_beat_cnt !== 32'd3 || stat_pkt_cnt !== 32'd1) begin
            $display("FAIL stall_stats got stall=%0d beat=%0d pkt=%0d exp 3 3 1", stat_stall_cnt, stat_beat_cnt, stat_pkt_cnt);
            errors++;
        end
        checks++;
`endif
    endtask

    task automatic test_stop_infinite();
        bit ok;
        int v_after;
        clear_mon();
        set_cfg(32'd16, 2'd0, 32'd0, 32'd1, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd1);
        pulse_start();
        repeat (2) tick();
        stream_start = 1'b1;
        tick();
        stream_start = 1'b0;
        tick();
        stream_stop = 1'b1;
        wait_done(100, ok);
        if (!ok) begin $display("FAIL stop_done_timeout got none exp done"); errors++; end
        checks++;
        v_after = valid_cnt;
        repeat (10) tick();
        stream_stop = 1'b0;
        if (valid_cnt != v_after) begin $display("FAIL stop_no_more_valid got %0d exp %0d", valid_cnt, v_after); errors++; end
        checks++;
        if (beats.size() != 8) begin $display("FAIL stop_beat_count got %0d exp 8", beats.size()); errors++; end
        checks++;
        if (beats.size() == 8) begin
            if (beats[3].last !== 1'b1 || beats[7].last !== 1'b1 || beats[7].tid !== 8'd1 || beats[6].last !== 1'b0) begin
                $display("FAIL stop_tlast got l3=%b l6=%b l7=%b id7=%h exp 1 0 1 01",
                         beats[3].last, beats[6].last, beats[7].last, beats[7].tid);
                errors++;
            end
            checks++;
            if (beats[7].cyc - beats[0].cyc != 7) begin $display("FAIL stop_valid_held got span %0d exp 7", beats[7].cyc - beats[0].cyc); errors++; end
            checks++;
        end
        if (done_cnt != 1) begin $display("FAIL stop_done_once got %0d exp 1", done_cnt); errors++; end
        checks++;
    endtask

    task automatic test_zero_pkts();
        bit ok;
        clear_mon();
        set_cfg(32'd4, 2'd0, 32'd0, 32'd1, 32'd0, 32'd0, 5'd0, 5'd1);
        pulse_start();
        wait_done(20, ok);
        if (!ok || valid_cnt != 0) begin $display("FAIL zero_pkts got done=%b valid=%0d exp 1 0", ok, valid_cnt); errors++; end
        checks++;
    endtask

    task automatic test_lfsr_reset();
        logic [31:0] exp_d[5] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001, 32'h00000001};
        bit ok;
        clear_mon();
        set_cfg(32'd16, 2'd2, 32'd0, 32'd1, 32'd0, 32'd2, 5'd0, 5'd1);
        pulse_start();
        repeat (6) tick();
        if (beats.size() < 5) begin $display("FAIL lfsr_beat_count got %0d exp >=5", beats.size()); errors++; end
        checks++;
        if (beats.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                if (beats[i].data !== exp_d[i]) begin
                    $display("FAIL lfsr_beat%0d got %h exp %h", i, beats[i].data, exp_d[i]);
                    errors++;
                end
                checks++;
            end
        end
        rstn = 1'b0;
        #1;
        if (m_axis_if.tvalid !== 1'b0 || stream_busy !== 1'b0) begin
            $display("FAIL async_reset got v=%b b=%b exp 0 0", m_axis_if.tvalid, stream_busy);
            errors++;
        end
        checks++;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        clear_mon();
        set_cfg(32'd4, 2'd0, 32'h55, 32'd1, 32'd0, 32'd2, 5'd9, 5'd1);
        pulse_start();
        wait_done(50, ok);
        if (!ok) begin $display("FAIL rerun_done_timeout got none exp done"); errors++; end
        checks++;
        if (beats.size() != 2) begin $display("FAIL rerun_beat_count got %0d exp 2", beats.size()); errors++; end
        checks++;
        if (beats.size() == 2) begin
            if (beats[0].tid !== 8'd0 || beats[1].tid !== 8'd1 || beats[0].data !== 32'h55 ||
                beats[1].data !== 32'h55 || beats[0].dest !== 5'd9 || beats[0].last !== 1'b1) begin
                $display("FAIL rerun_payload got id=%h,%h d=%h,%h dst=%h l=%b exp 00,01 55,55 09 1",
                         beats[0].tid, beats[1].tid, beats[0].data, beats[1].data, beats[0].dest, beats[0].last);
                errors++;
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_incr_b2b();
        test_fixed_partial();
        test_gap_dest();
        test_stall();
        test_stop_infinite();
        test_zero_pkts();
        test_lfsr_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/util_stream_gen.md
Name: util_stream_gen

Overview:
Parametrised AXI4-Stream packet generator, successor to util_stream_master. Adds byte-granular packet length with partial last-beat tkeep, a selectable data pattern (increment, fixed, LFSR), destination rotation across several channels, and graceful stop. Used as a traffic source for DMA, FIFO and interconnect bring-up in simulation and on hardware.

Parameters:
TBYTE_NUM, 4, bytes per beat; tdata width = TBYTE_NUM*8, range 1..64
DEST_WIDTH, 5, width of m_axis_tdest and cfg_dest_base
TID_WIDTH, 8, width of m_axis_tid, carries the low bits of the packet sequence number

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
cfg_dest_base  in  DEST_WIDTH  first tdest value
cfg_dest_num  in  DEST_WIDTH  number of dests to rotate through; 0 is treated as 1
cfg_gap  in  32  idle cycles between packets
cfg_pkt_num  in  32  packets per run; 32'hFFFFFFFF means infinite; 0 means finish immediately
cfg_len_bytes  in  32  bytes per packet; 0 is treated as 1
cfg_start_from  in  TBYTE_NUM*8  first data word, or LFSR seed
cfg_inc  in  TBYTE_NUM*8  per-beat increment
cfg_mode  in  2  0 increment, 1 fixed, 2 LFSR, 3 fixed
stream_start  in  1  a rising edge starts a run
stream_stop  in  1  level; stops the run after the current packet
stream_busy  out  1  high while a run is active
stream_done  out  1  one-cycle pulse when a run ends
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tdata  out  TBYTE_NUM*8  AXIS data
m_axis_tkeep  out  TBYTE_NUM  AXIS byte enables
m_axis_tlast  out  1  last beat of a packet
m_axis_tid  out  TID_WIDTH  packet sequence number, low bits
m_axis_tdest  out  DEST_WIDTH  destination

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, the start edge detector is cleared. Reset asserted mid-packet aborts immediately; no tlast is required.
- stream_start is registered for edge detection. Edges arriving while busy are ignored.
- All cfg_* inputs are latched on the start edge. Later changes have no effect until the next run.
- FSM states: IDLE, SEND, GAP, FIN.
  - IDLE -> SEND on a start edge. stream_busy=1 and tvalid=1 from the next cycle, so the first beat appears one cycle after the edge is detected.
  - IDLE -> FIN if the latched pkt_num is 0.
  - SEND: a beat completes on tvalid&tready.
  - On the tlast handshake: the packet counter increments. Go to FIN if the count reaches pkt_num (never, when pkt_num is infinite) or stream_stop is high. Otherwise go to GAP if gap>0, or start the next packet the following cycle if gap=0 (back-to-back, tvalid stays high).
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND. stream_stop high during GAP goes to FIN.
  - FIN: stream_done=1 for one cycle, stream_busy=0, tvalid=0, then IDLE.
- Beats per packet = ceil(len/TBYTE_NUM), computed with a 32-bit beat counter.
- tkeep is all ones except on the last beat, which carries the low (len mod TBYTE_NUM) bits set, or all ones if the remainder is 0. tlast is high only on the last beat.
- Data pattern is reloaded to cfg_start_from at every packet start and advances once per handshake:
  - mode 0: data += inc, modulo 2^(TBYTE_NUM*8).
  - mode 1: data constant.
  - mode 2: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded from start_from[31:0]. A seed of 0 is replaced by 1. The 32-bit value is replicated or truncated to fill tdata.
- tdest starts at dest_base for packet 0 and advances by 1 per packet, wrapping to dest_base after dest_num packets. Sum is modulo 2^DEST_WIDTH.
- tid = packet index mod 2^TID_WIDTH, starting at 0 each run.
- AXIS rule: while tvalid&!tready, tdata, tkeep, tlast, tid and tdest stay stable and tvalid stays high. tvalid never drops mid-packet, including when stream_stop asserts.

Optional Feature:
Macro UTIL_STREAM_GEN_STAT_EN. When defined, three 32-bit outputs are added, each cleared on the start edge and saturating at all ones:
- stat_pkt_cnt: completed packets.
- stat_beat_cnt: handshaked beats.
- stat_stall_cnt: cycles with tvalid&!tready.
When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- TBYTE_NUM=4, len=8, mode 0, start_from=0, inc=1, gap=0, pkt_num=3, tready=1 -> 6 beats back-to-back with data 0,1 per packet; tlast on beats 2, 4 and 6; tid 0,1,2; stream_done pulses once and busy falls on the same cycle.
- len=10, mode 1, start_from=32'hA5A5A5A5, pkt_num=1 -> 3 beats, tkeep F, F, 3; last beat has tlast; data constant.
- gap=5, dest_base=2, dest_num=3, pkt_num=4 -> tdest 2,3,4,2; exactly 5 tvalid-low cycles between tlast and the next first beat.
- tready toggling 1,0,0,1 during a packet, with the stat macro defined -> payload stable during stalls; stat_stall_cnt equals the count of stalled cycles; stat_beat_cnt equals the beat count.
- pkt_num=32'hFFFFFFFF, stream_stop raised mid-packet -> the current packet completes with tlast, then done pulses and no further tvalid appears; a start edge during busy is ignored.
- mode 2, seed 0 -> the first beat is 1 and later beats follow the LFSR sequence; rstn dropped mid-packet -> tvalid=0 asynchronously, and the next run starts cleanly with tid 0.
